// File: rtl/bk_pkg.sv
// Shared types and elaboration helpers for the pipelined Brent-Kung adder.
package bk_pkg;

    typedef struct packed {
        logic g;
        logic p;
    } gp_t;

    // Prefix operator: hi covers the more significant span, lo the less significant one.
    function automatic gp_t gp_combine(gp_t hi, gp_t lo);
        gp_t r;
        r.g = hi.g | (hi.p & lo.g);
        r.p = hi.p & lo.p;
        return r;
    endfunction

    function automatic int unsigned bk_levels(int unsigned width);
        return 32'(2 * $clog2(width) - 1);
    endfunction

    function automatic int unsigned rank_after_level(int unsigned i, int unsigned stages,
                                                     int unsigned levels);
        return (i * (levels + 1)) / stages;
    endfunction

endpackage

// File: rtl/bk_prefix_level.sv
// One combinational Brent-Kung prefix level: up-sweep for LEVEL < LG, down-sweep above.
module bk_prefix_level
    import bk_pkg::*;
#(
    parameter int unsigned N     = 16,
    parameter int unsigned LG    = 4,
    parameter int unsigned LEVEL = 0
) (
    input  gp_t [N-1:0] gp_in,
    output gp_t [N-1:0] gp_out
);

    localparam bit          UP   = (LEVEL < LG);
    localparam int unsigned SPAN = UP ? (1 << LEVEL) : (1 << (2 * LG - 2 - LEVEL));

    // Up-sweep combines at the top of each 2*SPAN block; down-sweep fills the odd multiples of SPAN.
    for (genvar i = 0; i < N; i++) begin : g_bit
        localparam int unsigned K   = i + 1;
        localparam bit          ACT = UP ? (K % (2 * SPAN) == 0)
                                         : ((K % (2 * SPAN) == SPAN) && (K > SPAN));
        if (ACT) begin : g_op
            assign gp_out[i] = gp_combine(gp_in[i], gp_in[i - SPAN]);
        end else begin : g_pass
            assign gp_out[i] = gp_in[i];
        end
    end

endmodule

// File: rtl/bk_adder_pipe.sv
// Pipelined Brent-Kung adder/subtractor with an elastic valid/ready pipeline.
module bk_adder_pipe
    import bk_pkg::*;
#(
    parameter int unsigned WIDTH  = 12,
    parameter int unsigned STAGES = 2
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             cin,
    input  logic             sub,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] sum,
    output logic             cout,
    output logic             ovf
);

    localparam int unsigned LG     = $clog2(WIDTH);
    localparam int unsigned N      = 2 ** LG;
    localparam int unsigned LEVELS = bk_levels(WIDTH);

    // Rank number (1..STAGES-1) registered after prefix level pos, or 0 if none.
    function automatic int unsigned rank_at(int unsigned pos);
        int unsigned r = 0;
        for (int unsigned i = 1; i < STAGES; i++) begin
            if (rank_after_level(i, STAGES, LEVELS) == pos) r = i;
        end
        return r;
    endfunction

    logic [STAGES-1:0] vld;
    logic [STAGES-1:0] ld;
    logic [STAGES-1:0] vin;
    logic [STAGES-1:0] en;

    logic [WIDTH-1:0]  b_eff;
    logic              c0;
    gp_t  [N-1:0]      gp0;

    gp_t  [N-1:0]      gp_d [1:LEVELS];
    gp_t  [N-1:0]      gp_q [0:LEVELS];
    logic [WIDTH-1:0]  p_q  [0:LEVELS];
    logic              c0_q [0:LEVELS];

    logic [WIDTH-1:0]  carry;
    logic [WIDTH-1:0]  sum_c;
    logic              cout_c;
    logic              ovf_c;
    logic              unused_gp;

    // Ready chain: a rank accepts when empty or when the rank after it moves.
    always_comb begin
        ld = '0;
        vin = '0;
        ld[STAGES-1] = !vld[STAGES-1] | out_ready;
        for (int r = int'(STAGES) - 2; r >= 0; r--) begin
            ld[r] = !vld[r] | ld[r+1];
        end
        vin[0] = in_valid;
        for (int r = 1; r < int'(STAGES); r++) begin
            vin[r] = vld[r-1];
        end
        en = ld & vin;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            vld <= '0;
        end else begin
            vld <= (vld & ~ld) | (vin & ld);
        end
    end

    assign in_ready  = ld[0];
    assign out_valid = vld[STAGES-1];

    // Operand conditioning; carry-in is folded into bit 0 so the tree yields every carry.
    always_comb begin
        b_eff = sub ? ~b : b;
        c0    = sub | cin;
        gp0   = '0;
        for (int i = 0; i < int'(WIDTH); i++) begin
            gp0[i].g = a[i] & b_eff[i];
            gp0[i].p = a[i] ^ b_eff[i];
        end
        gp0[0].g = gp0[0].g | (gp0[0].p & c0);
    end

    assign gp_q[0] = gp0;
    assign p_q[0]  = a ^ b_eff;
    assign c0_q[0] = c0;

    for (genvar j = 1; j <= int'(LEVELS); j++) begin : g_lvl
        localparam int unsigned RANK = rank_at(j);

        bk_prefix_level #(
            .N    (N),
            .LG   (LG),
            .LEVEL(j - 1)
        ) u_level (
            .gp_in (gp_q[j-1]),
            .gp_out(gp_d[j])
        );

        if (RANK != 0) begin : g_rank
            gp_t  [N-1:0]     gp_r;
            logic [WIDTH-1:0] p_r;
            logic             c0_r;

            always_ff @(posedge clk or negedge rst_n) begin
                if (!rst_n) begin
                    gp_r <= '0;
                    p_r  <= '0;
                    c0_r <= 1'b0;
                end else if (en[RANK-1]) begin
                    gp_r <= gp_d[j];
                    p_r  <= p_q[j-1];
                    c0_r <= c0_q[j-1];
                end
            end

            assign gp_q[j] = gp_r;
            assign p_q[j]  = p_r;
            assign c0_q[j] = c0_r;
        end else begin : g_thru
            assign gp_q[j] = gp_d[j];
            assign p_q[j]  = p_q[j-1];
            assign c0_q[j] = c0_q[j-1];
        end
    end

    // Carry into bit i is the group generate of bits [i-1:0].
    always_comb begin
        carry    = '0;
        carry[0] = c0_q[LEVELS];
        for (int i = 1; i < int'(WIDTH); i++) begin
            carry[i] = gp_q[LEVELS][i-1].g;
        end
    end

    assign sum_c     = p_q[LEVELS] ^ carry;
    assign cout_c    = gp_q[LEVELS][WIDTH-1].g;
    assign ovf_c     = carry[WIDTH-1] ^ cout_c;
    assign unused_gp = ^gp_q[LEVELS];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sum  <= '0;
            cout <= 1'b0;
            ovf  <= 1'b0;
        end else if (en[STAGES-1]) begin
            sum  <= sum_c;
            cout <= cout_c;
            ovf  <= ovf_c;
        end
    end

endmodule

// File: tb/tb_bk_adder_pipe.sv
// Directed checks on a 12-bit/2-stage adder plus randomized regression over widths and depths.
module tb_bk_adder_pipe;

    localparam int NCFG       = 32;
    localparam int NBEATS     = 60;
    localparam int RND_BUDGET = 2000;

    logic clk;
    logic rst_n;
    logic go;
    int   done_cnt;
    int   errors;
    int   checks;

    logic        m_in_valid, m_in_ready, m_out_valid, m_out_ready;
    logic        m_cin, m_sub, m_cout, m_ovf;
    logic [11:0] m_a, m_b, m_sum;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [127:0] got, input logic [127:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Config table: every legal STAGES for WIDTH 2, 12, 32 and 64.
    function automatic int unsigned cfg_w(int k);
        if (k < 2)  return 2;
        if (k < 10) return 12;
        if (k < 20) return 32;
        return 64;
    endfunction

    function automatic int unsigned cfg_s(int k);
        if (k < 2)  return 32'(k + 1);
        if (k < 10) return 32'(k - 1);
        if (k < 20) return 32'(k - 9);
        return 32'(k - 19);
    endfunction

    bk_adder_pipe #(
        .WIDTH (12),
        .STAGES(2)
    ) u_dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .in_valid (m_in_valid),
        .in_ready (m_in_ready),
        .a        (m_a),
        .b        (m_b),
        .cin      (m_cin),
        .sub      (m_sub),
        .out_valid(m_out_valid),
        .out_ready(m_out_ready),
        .sum      (m_sum),
        .cout     (m_cout),
        .ovf      (m_ovf)
    );

    // One beat in, expect it after exactly two cycles.
    task automatic op_check(input string tag, input logic [11:0] x, input logic [11:0] y,
                            input logic c, input logic s, input logic [11:0] es,
                            input logic ec, input logic eo);
        m_in_valid  = 1'b1;
        m_a         = x;
        m_b         = y;
        m_cin       = c;
        m_sub       = s;
        m_out_ready = 1'b1;
        @(negedge clk);
        check({tag, "_in_ready"}, 128'(m_in_ready), 128'(1));
        tick();
        m_in_valid = 1'b0;
        check({tag, "_early"}, 128'(m_out_valid), 128'(0));
        tick();
        check({tag, "_valid"}, 128'(m_out_valid), 128'(1));
        check({tag, "_sum"}, 128'(m_sum), 128'(es));
        check({tag, "_cout"}, 128'(m_cout), 128'(ec));
        check({tag, "_ovf"}, 128'(m_ovf), 128'(eo));
        tick();
    endtask

    for (genvar k = 0; k < NCFG; k++) begin : g_rnd
        localparam int unsigned W = cfg_w(k);
        localparam int unsigned S = cfg_s(k);

        logic         r_in_valid, r_in_ready, r_out_valid, r_out_ready;
        logic         r_cin, r_sub, r_cout, r_ovf;
        logic [W-1:0] r_a, r_b, r_sum;
        logic [W+1:0] sb_q [$];
        logic [W+1:0] exp_beat;
        logic [W+1:0] last_out;
        logic         held;
        logic         stalled;
        int           sent;
        int           cyc;
        string        tag;

        bk_adder_pipe #(
            .WIDTH (W),
            .STAGES(S)
        ) u_dut (
            .clk      (clk),
            .rst_n    (rst_n),
            .in_valid (r_in_valid),
            .in_ready (r_in_ready),
            .a        (r_a),
            .b        (r_b),
            .cin      (r_cin),
            .sub      (r_sub),
            .out_valid(r_out_valid),
            .out_ready(r_out_ready),
            .sum      (r_sum),
            .cout     (r_cout),
            .ovf      (r_ovf)
        );

        // Reference {ovf, cout, sum} from signed/unsigned arithmetic on the operands.
        function automatic logic [W+1:0] ref_beat(input logic [W-1:0] x, input logic [W-1:0] y,
                                                  input logic c, input logic s);
            logic signed [W:0] sx, sy, sr;
            logic [W:0]        ut;
            logic              carry;
            sx = $signed({x[W-1], x});
            sy = $signed({y[W-1], y});
            ut = '0;
            if (s) begin
                sr    = sx - sy;
                carry = (x >= y);
            end else begin
                sr    = sx + sy + $signed({{W{1'b0}}, c});
                ut    = {1'b0, x} + {1'b0, y} + {{W{1'b0}}, c};
                carry = ut[W];
            end
            return {sr[W] ^ sr[W-1], carry, sr[W-1:0]};
        endfunction

        initial begin
            r_in_valid  = 1'b0;
            r_out_ready = 1'b0;
            r_a         = '0;
            r_b         = '0;
            r_cin       = 1'b0;
            r_sub       = 1'b0;
            held        = 1'b0;
            stalled     = 1'b0;
            last_out    = '0;
            sent        = 0;
            cyc         = 0;
            tag         = $sformatf("w%0d_s%0d", W, S);
            wait (go);
            while ((sent < NBEATS || sb_q.size() != 0) && cyc < RND_BUDGET) begin
                @(negedge clk);
                if (stalled) begin
                    check({tag, "_hold_valid"}, 128'(r_out_valid), 128'(1));
                    check({tag, "_hold_data"}, 128'({r_ovf, r_cout, r_sum}), 128'(last_out));
                end
                if (!held) begin
                    r_in_valid = (sent < NBEATS) && ($urandom_range(3) != 0);
                    r_a        = ($urandom_range(7) == 0) ? '1 : W'({$urandom, $urandom});
                    r_b        = ($urandom_range(7) == 0) ? '1 : W'({$urandom, $urandom});
                    r_cin      = 1'($urandom);
                    r_sub      = 1'($urandom);
                end
                r_out_ready = ($urandom_range(3) != 0);
                #1;
                check({tag, "_in_ready"}, 128'(r_in_ready),
                      128'((sb_q.size() < int'(S)) || r_out_ready));
                if (r_out_valid && r_out_ready) begin
                    if (sb_q.size() == 0) begin
                        check({tag, "_extra_beat"}, 128'(r_out_valid), 128'(0));
                    end else begin
                        exp_beat = sb_q.pop_front();
                        check({tag, "_beat"}, 128'({r_ovf, r_cout, r_sum}), 128'(exp_beat));
                    end
                end
                if (r_in_valid && r_in_ready) begin
                    sb_q.push_back(ref_beat(r_a, r_b, r_cin, r_sub));
                    sent++;
                end
                held     = r_in_valid && !r_in_ready;
                stalled  = r_out_valid && !r_out_ready;
                last_out = {r_ovf, r_cout, r_sum};
                cyc++;
            end
            r_in_valid = 1'b0;
            check({tag, "_drained"}, 128'(sb_q.size()), 128'(0));
            check({tag, "_sent"}, 128'(sent), 128'(NBEATS));
            done_cnt++;
        end
    end

    initial begin
        int idx;
        int nout;
        int first;
        int last;
        int stale;

        errors      = 0;
        checks      = 0;
        go          = 1'b0;
        done_cnt    = 0;
        rst_n       = 1'b0;
        m_in_valid  = 1'b0;
        m_a         = '0;
        m_b         = '0;
        m_cin       = 1'b0;
        m_sub       = 1'b0;
        m_out_ready = 1'b1;
        repeat (3) @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        tick();
        check("rst_out_valid", 128'(m_out_valid), 128'(0));
        check("rst_sum", 128'(m_sum), 128'(0));
        check("rst_cout", 128'(m_cout), 128'(0));
        check("rst_ovf", 128'(m_ovf), 128'(0));
        check("rst_in_ready", 128'(m_in_ready), 128'(1));

        op_check("ripple", 12'hFFF, 12'h001, 1'b0, 1'b0, 12'h000, 1'b1, 1'b0);
        op_check("sub", 12'h005, 12'h007, 1'b0, 1'b1, 12'hFFE, 1'b0, 1'b0);
        op_check("sovf", 12'h7FF, 12'h001, 1'b0, 1'b0, 12'h800, 1'b0, 1'b1);
        op_check("cin", 12'h123, 12'h456, 1'b1, 1'b0, 12'h57A, 1'b0, 1'b0);
        op_check("sub_ovf", 12'h800, 12'h001, 1'b0, 1'b1, 12'h7FF, 1'b1, 1'b1);

        // Backpressure: five beats offered while the consumer stalls.
        m_out_ready = 1'b0;
        idx = 0;
        for (int c = 0; c < 6; c++) begin
            m_in_valid = 1'b1;
            m_a        = 12'(32'h100 + idx);
            m_b        = 12'(idx);
            m_cin      = 1'b0;
            m_sub      = 1'b0;
            @(negedge clk);
            if (m_in_ready) idx++;
            tick();
        end
        check("bp_accepted", 128'(idx), 128'(2));
        check("bp_in_ready_low", 128'(m_in_ready), 128'(0));
        check("bp_out_valid", 128'(m_out_valid), 128'(1));

        m_out_ready = 1'b1;
        nout  = 0;
        first = -1;
        last  = -1;
        for (int c = 0; c < 20 && nout < 5; c++) begin
            m_in_valid = (idx < 5);
            m_a        = 12'(32'h100 + idx);
            m_b        = 12'(idx);
            @(negedge clk);
            if (m_out_valid) begin
                check($sformatf("bp_beat%0d", nout), 128'(m_sum), 128'(12'(32'h100 + 2 * nout)));
                if (first < 0) first = c;
                last = c;
                nout++;
            end
            if (m_in_valid && m_in_ready) idx++;
            tick();
        end
        m_in_valid = 1'b0;
        check("bp_count", 128'(nout), 128'(5));
        check("bp_rate", 128'(last - first), 128'(4));

        // Reset with two beats in flight must discard both.
        m_out_ready = 1'b0;
        idx = 0;
        for (int c = 0; c < 10 && idx < 2; c++) begin
            m_in_valid = 1'b1;
            m_a        = 12'h0AA;
            m_b        = 12'h055;
            @(negedge clk);
            if (m_in_ready) idx++;
            tick();
        end
        m_in_valid = 1'b0;
        check("mr_loaded", 128'(m_out_valid), 128'(1));
        #2 rst_n = 1'b0;
        #1;
        check("mr_async", 128'(m_out_valid), 128'(0));
        tick();
        tick();
        @(negedge clk);
        rst_n       = 1'b1;
        m_out_ready = 1'b1;
        stale = 0;
        repeat (6) begin
            tick();
            if (m_out_valid) stale++;
        end
        check("mr_stale", 128'(stale), 128'(0));
        check("mr_sum", 128'(m_sum), 128'(0));
        check("mr_in_ready", 128'(m_in_ready), 128'(1));

        go = 1'b1;
        for (int t = 0; t < 20000 && done_cnt < NCFG; t++) @(posedge clk);
        check("rnd_done", 128'(done_cnt), 128'(NCFG));

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/bk_adder_pipe.md
# bk_adder_pipe

Parametrised, pipelined Brent-Kung prefix adder/subtractor with valid/ready handshaking. It supersedes the fixed 12-bit combinational BrentKung netlist. Width and pipeline depth are parameters, and it adds carry-in, subtract mode, signed-overflow detection and backpressure. It sits between operand-producing datapath blocks and result consumers, and it is the synthesis benchmark for timing-driven optimisation runs.

## Interface
- `WIDTH`, default 12: operand width in bits, ≥2. The prefix tree is padded internally to the next power of two.
- `STAGES`, default 2: number of pipeline register ranks, 1 ≤ STAGES ≤ LEVELS+1.
  - LEVELS = 2·⌈log2 WIDTH⌉−1 Brent-Kung prefix levels.
- `clk` in 1: single clock, rising edge.
- `rst_n` in 1: reset, asynchronous, active-low.
- `in_valid` in 1: operand beat valid.
- `in_ready` out 1: block can accept a beat this cycle.
- `a` in WIDTH: operand A.
- `b` in WIDTH: operand B.
- `cin` in 1: carry-in. In subtract mode it is ignored and forced to 1.
- `sub` in 1: 1 selects A−B (A + ~B + 1); 0 selects A+B+cin.
- `out_valid` out 1: result beat valid.
- `out_ready` in 1: consumer accepts the result.
- `sum` out WIDTH: result, modulo 2^WIDTH.
- `cout` out 1: carry out of the MSB. In subtract mode, 1 means no borrow (A ≥ B unsigned).
- `ovf` out 1: two's-complement signed overflow, equal to carry into MSB XOR carry out of MSB.

## Operation
- Stage 0 (combinational, before rank 1):
  - b_eff = sub ? ~b : b.
  - c0 = sub | cin.
  - Per-bit g = a&b_eff, p = a^b_eff.
  - c0 folds into bit 0 as g0' = g0 | (p0&c0).
- Prefix network:
  - Up-sweep: ⌈log2 WIDTH⌉ levels with (G,P) ∘ operator at span 2^k.
  - Down-sweep: ⌈log2 WIDTH⌉−1 levels filling the remaining carries.
- Pipeline rank placement: ranks are placed after levels ⌊i·(LEVELS+1)/STAGES⌋, for i = 1..STAGES−1. The final rank registers the outputs.
- Post-processing: sum_i = p_i ^ c_i, where c_0 = c0 and c_i = G[i−1:0].
- Padding bits (above WIDTH) carry g=p=0 and never affect cout or ovf.
- Each rank holds a valid bit plus the (G,P) bits still live at that point; p bits are carried forward to the sum.
- Elastic pipeline with bubble collapse:
  - Rank k loads when !v[k] or rank k+1 loads (last rank: !v[last] or out_ready).
  - in_ready = load condition of rank 1.
  - out_valid = v[last].
- Transfer rules:
  - An input beat transfers when in_valid & in_ready.
  - An output beat transfers when out_valid & out_ready.
  - Beats stay in order; none is lost or duplicated.
- Data registers load only on transfer. Holding out_valid with out_ready low keeps sum/cout/ovf stable.

## Timing
- Latency from input transfer to out_valid is STAGES cycles when the pipeline is unstalled.
- Throughput is 1 beat/cycle with out_ready held high.
- Capacity is STAGES beats. With out_ready low, in_ready falls after STAGES beats are accepted.
- in_ready depends combinationally on out_ready (ready chain). No combinational path exists from a, b, cin or sub to any output.
- Reset (async assert, synchronous deassert by the system):
  - All valid bits are 0, so out_valid=0. in_ready=1 from the first cycle after reset.
  - sum=0, cout=0, ovf=0.
- Reset mid-operation: all in-flight beats are discarded and none appear after release.
- Simultaneous input and output transfer on a full pipeline: both occur and occupancy is unchanged.
- in_valid with in_ready low: inputs are ignored. The producer must hold them.

## Structure
- Package `bk_pkg` holds:
  - `gp_t` struct {g,p}.
  - function `gp_combine(hi,lo)` returning {hi.g|(hi.p&lo.g), hi.p&lo.p}.
  - function `bk_levels(width)`.
  - function `rank_after_level(i, stages, levels)`.
- Sub-module `bk_prefix_level`: one combinational prefix level, parametrised by level index and padded width. It is generated LEVELS times in the top.
- The top holds operand conditioning, the generate loop, rank registers, valid/ready logic and post-processing.

## Test plan
- Reset with WIDTH=12, STAGES=2: out_valid=0, sum=0x000, in_ready=1 at the first edge after rst_n rises.
- Carry ripple: a=0xFFF, b=0x001, cin=0, sub=0 → after 2 cycles sum=0x000, cout=1, ovf=0.
- Subtract: a=0x005, b=0x007, sub=1 → sum=0xFFE, cout=0, ovf=0.
- Signed overflow: a=0x7FF, b=0x001, sub=0 → sum=0x800, ovf=1, cout=0.
- Backpressure: hold out_ready=0 and stream 5 beats → in_ready drops after 2 accepted. Raising out_ready drains all 5 in order at 1/cycle.
- Reset mid-operation and parameter sweep:
  - Assert rst_n low with 2 beats in flight → no stale output after release.
  - Random regression for WIDTH ∈ {2, 12, 32, 64}, all legal STAGES, against a behavioural a±b reference model.
